tagged_mem_responder: RTL and testbench
=======================================

TAGGED_MEM_RESPONDER -- requirements
Module: tagged_mem_responder

Interface
REQ-001 Parameters SHALL be: MEM_WORDS, 1024, number of 32-bit words in the array; LATENCY, 4, cycles from load acceptance to completion (legal 1..8); MAX_OUTSTANDING, 4, load slots (legal 1..15).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst as elsewhere in the codebase.
REQ-003 Port list, in order:
- clk: input, 1 bit, rising-edge clock.
- rst: input, 1 bit, asynchronous, active-low reset.
- proc2mem_addr: input, 32 bits, byte address; word index is addr[31:2] and addr[1:0] is ignored.
- proc2mem_data: input, 32 bits, store data.
- proc2mem_command: input, 2 bits; 0 = none, 1 = load, 2 = store, 3 = reserved and treated as none.
- mem2proc_response: output, 4 bits, combinational; acceptance tag, where 0 = rejected or no request.
- mem2proc_data: output, 32 bits, registered; load data, valid when mem2proc_tag != 0.
- mem2proc_tag: output, 4 bits, registered; tag of the completing load, where 0 = no completion.

Function
REQ-004 The tag counter SHALL be 4 bits wide, reset to 1, and advance by 1 on every accepted load or store, wrapping from 15 to 1 so that it never holds 0.
REQ-005 mem2proc_response SHALL equal the current tag counter, in the same cycle, when the command is accepted, and SHALL be 0 otherwise.
REQ-006 A store SHALL always be accepted and SHALL produce no completion.
- If index < MEM_WORDS, the store writes the array at the end of the accepting cycle.
- If index >= MEM_WORDS, the store is acknowledged and its data is dropped.
REQ-007 A load SHALL be accepted iff outstanding < MAX_OUTSTANDING, where outstanding is sampled at the start of the cycle.
- A load completing in that same cycle still counts as occupying its slot.
REQ-008 An accepted load SHALL snapshot its array data at acceptance.
- An out-of-range index snapshots 32'h0.
- The snapshot, together with the load's tag, enters a LATENCY-stage in-order delay pipeline.
REQ-009 A load accepted in cycle t SHALL present its tag and data on mem2proc_tag and mem2proc_data during cycle t+LATENCY, for exactly one cycle.
REQ-010 In any cycle without a completion, mem2proc_tag SHALL be 0 and mem2proc_data SHALL be 32'h0.
REQ-011 The outstanding count SHALL be updated once per cycle:
- +1 when a load is accepted;
- -1 when a load completes;
- unchanged when both occur in the same cycle.
- The count never exceeds MAX_OUTSTANDING and never goes below 0.
REQ-012 A store accepted in cycle t SHALL be visible to a load accepted in cycle t+1 or later.
- A load accepted before the store returns the old value.
REQ-013 A rejected load SHALL NOT advance the tag counter, alter the pipeline, or alter the count.
- The requester re-presents the load in a later cycle.
REQ-014 Completions SHALL be returned strictly in acceptance order, with at most one completion per cycle.
REQ-015 The array contents SHALL NOT be affected by reset.
- The bench preloads the array through a hierarchical array named memory.

Reset
REQ-016 While rst = 0, all of the following SHALL hold:
- tag counter = 1;
- outstanding = 0;
- all pipeline stages invalid;
- mem2proc_tag = 0 and mem2proc_data = 32'h0;
- mem2proc_response = 0, so all commands are rejected;
- no array writes occur.
REQ-017 Asserting rst while loads are in flight SHALL discard them, and no completion for any pre-reset tag SHALL appear after rst is released.
REQ-018 After rst is released, the first accepted command SHALL receive tag 1.

Verification
REQ-019 Store-then-load: store 32'hDEADBEEF to 0x10 in cycle 1, then load 0x10 in cycle 2.
- Responses are 1 and 2.
- mem2proc_tag = 2 and mem2proc_data = 32'hDEADBEEF in cycle 2+LATENCY.
REQ-020 Backpressure: with LATENCY = 4 and MAX_OUTSTANDING = 4, issue five consecutive loads starting in cycle 1.
- Responses are 1, 2, 3, 4, 0.
- The fifth load, re-presented in cycle 5 (the cycle in which the first load completes), is still rejected.
- Re-presented in cycle 6, it is accepted with tag 5.
REQ-021 Tag wrap: issue 16 accepted stores.
- Responses run 1..15 and then 1.
- 0 never appears on an accepted command.
REQ-022 Out of range: load 0x00001000 (index 1024) with MEM_WORDS = 1024.
- The load is accepted.
- Its completion carries data 32'h0.
- A store to the same address leaves array words 0..1023 unchanged.
REQ-023 Reset mid-flight: accept loads with tags 1 and 2, then assert rst for 1 cycle before either completes.
- No completion with tag 1 or 2 appears afterwards.
- The next accepted command gets tag 1.
REQ-024 Load-before-store ordering: load 0x20, which holds 32'h11, in cycle 1, then store 32'h22 to 0x20 in cycle 2.
- The completion returns 32'h11.
- A load of 0x20 in cycle 3 returns 32'h22.

Source files
------------

// File: rtl/tagged_mem_responder.sv
// rtl/tagged_mem_responder.sv - tagged load/store memory responder with fixed-latency in-order load completions
// Loads snapshot the array at acceptance and travel a LATENCY-deep delay line.
module tagged_mem_responder #(
  parameter int MEM_WORDS       = 1024,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] proc2mem_addr,
  input  logic [31:0] proc2mem_data,
  input  logic [1:0]  proc2mem_command,
  output logic [3:0]  mem2proc_response,
  output logic [31:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam int         AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);
  localparam logic [29:0] WORDS  = 30'(MEM_WORDS);

  logic [31:0] memory [MEM_WORDS];

  logic [3:0]  tag_q, tag_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic [3:0]  pipe_tag_q  [LATENCY];
  logic [31:0] pipe_data_q [LATENCY];

  logic [29:0] word_idx;
  logic        in_range;
  logic        is_load;
  logic        is_store;
  logic        load_acc;
  logic        accept;
  logic        complete;
  logic [31:0] rd_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^proc2mem_addr[1:0];

  always_comb begin
    word_idx = proc2mem_addr[31:2];
    in_range = word_idx < WORDS;
    is_load  = rst && (proc2mem_command == 2'd1);
    is_store = rst && (proc2mem_command == 2'd2);
    // A load leaving the pipe this cycle still holds its slot until the edge.
    load_acc = is_load && (outstanding_q < MAX_OUT);
    accept   = load_acc || is_store;
    complete = pipe_tag_q[LATENCY-1] != 4'd0;
    rd_data  = in_range ? memory[word_idx[AW-1:0]] : 32'h0;

    mem2proc_response = accept ? tag_q : 4'd0;

    tag_d = tag_q;
    if (accept) begin
      tag_d = (tag_q == 4'd15) ? 4'd1 : tag_q + 4'd1;
    end

    outstanding_d = outstanding_q + {3'b000, load_acc} - {3'b000, complete};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q         <= 4'd1;
      outstanding_q <= 4'd0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_tag_q[i]  <= 4'd0;
        pipe_data_q[i] <= 32'h0;
      end
    end else begin
      tag_q          <= tag_d;
      outstanding_q  <= outstanding_d;
      // Empty slots carry tag 0 and zero data so the last stage drives the outputs directly.
      pipe_tag_q[0]  <= load_acc ? tag_q : 4'd0;
      pipe_data_q[0] <= load_acc ? rd_data : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_tag_q[i]  <= pipe_tag_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (is_store && in_range) begin
      memory[word_idx[AW-1:0]] <= proc2mem_data;
    end
  end

  assign mem2proc_tag  = pipe_tag_q[LATENCY-1];
  assign mem2proc_data = pipe_data_q[LATENCY-1];

endmodule

// File: tb/tb_tagged_mem_responder.sv
// tb/tb_tagged_mem_responder.sv - directed and random checks of tagged_mem_responder against a queue-based model
module tb_tagged_mem_responder;

  localparam int LAT   = 4;
  localparam int MAXO  = 4;
  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_s;
  logic [31:0] wdata_s;
  logic [1:0]  cmd_s;
  logic [3:0]  resp_o;
  logic [31:0] data_o;
  logic [3:0]  tag_o;

  tagged_mem_responder #(
    .MEM_WORDS(WORDS),
    .LATENCY(LAT),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .proc2mem_addr(addr_s),
    .proc2mem_data(wdata_s),
    .proc2mem_command(cmd_s),
    .mem2proc_response(resp_o),
    .mem2proc_data(data_o),
    .mem2proc_tag(tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    int          due;
  } pend_t;

  pend_t       q[$];
  logic [31:0] mem_m [WORDS];
  logic [3:0]  m_tag;
  int          cyc;
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  cap_tag[$];
  logic [31:0] cap_data[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", name, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive, predict from the model, check at negedge, then advance the model.
  task automatic step(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [3:0] resp, output logic [3:0] ctag, output logic [31:0] cdata);
    logic [3:0]  e_resp;
    logic [3:0]  e_ctag;
    logic [31:0] e_cdata;
    logic [29:0] idx;
    bit          inr;
    bit          ld;
    bit          st;
    bit          lok;
    cmd_s   = cmd;
    addr_s  = addr;
    wdata_s = wdata;
    idx     = addr[31:2];
    inr     = idx < WORDS;
    ld      = cmd == 2'd1;
    st      = cmd == 2'd2;
    lok     = q.size() < MAXO;
    e_ctag  = 4'd0;
    e_cdata = 32'h0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e_ctag  = q[0].tag;
      e_cdata = q[0].data;
    end
    e_resp = (st || (ld && lok)) ? m_tag : 4'd0;
    @(negedge clk);
    resp  = resp_o;
    ctag  = tag_o;
    cdata = data_o;
    check("response", {28'h0, resp_o}, {28'h0, e_resp});
    check("cpl_tag", {28'h0, tag_o}, {28'h0, e_ctag});
    check("cpl_data", data_o, e_cdata);
    @(posedge clk);
    #1;
    if (e_ctag != 4'd0) void'(q.pop_front());
    if (ld && lok) q.push_back('{tag: m_tag, data: (inr ? mem_m[idx[9:0]] : 32'h0), due: cyc + LAT});
    if (st && inr) mem_m[idx[9:0]] = wdata;
    if (e_resp != 4'd0) m_tag = (m_tag == 4'd15) ? 4'd1 : m_tag + 4'd1;
    cyc++;
  endtask

  // Holds rst low for one cycle with a store presented, which must be ignored.
  task automatic do_reset();
    rst     = 1'b0;
    cmd_s   = 2'd2;
    addr_s  = 32'h40;
    wdata_s = 32'hBAD0BAD0;
    @(negedge clk);
    check("rst_response", {28'h0, resp_o}, 32'h0);
    check("rst_tag", {28'h0, tag_o}, 32'h0);
    check("rst_data", data_o, 32'h0);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    cmd_s = 2'd0;
    q.delete();
    m_tag = 4'd1;
    cyc++;
  endtask

  task automatic idle_capture(input int n);
    logic [3:0]  r;
    logic [3:0]  ct;
    logic [31:0] cd;
    cap_tag.delete();
    cap_data.delete();
    for (int i = 0; i < n; i++) begin
      step(2'd0, 32'h0, 32'h0, r, ct, cd);
      if (ct != 4'd0) begin
        cap_tag.push_back(ct);
        cap_data.push_back(cd);
      end
    end
  endtask

  initial begin
    logic [3:0]  r;
    logic [3:0]  ct;
    logic [31:0] cd;
    logic [31:0] v;
    logic [31:0] a;
    logic [1:0]  c;
    logic [3:0]  exp20 [6];
    exp20 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd5};
    rst     = 1'b1;
    cmd_s   = 2'd0;
    addr_s  = 32'h0;
    wdata_s = 32'h0;
    m_tag   = 4'd1;
    cyc     = 0;
    #2;
    rst = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      v = $urandom;
      dut.memory[i] = v;
      mem_m[i] = v;
    end
    @(posedge clk);
    #1;
    do_reset();

    // Store then load
    step(2'd2, 32'h10, 32'hDEADBEEF, r, ct, cd);
    check("s2l_store_resp", {28'h0, r}, 32'd1);
    step(2'd1, 32'h10, 32'h0, r, ct, cd);
    check("s2l_load_resp", {28'h0, r}, 32'd2);
    idle_capture(LAT + 1);
    check("s2l_cpl_count", cap_tag.size(), 32'd1);
    if (cap_tag.size() > 0) begin
      check("s2l_cpl_tag", {28'h0, cap_tag[0]}, 32'd2);
      check("s2l_cpl_data", cap_data[0], 32'hDEADBEEF);
    end

    // Backpressure
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(2'd1, 32'(i * 4), 32'h0, r, ct, cd);
      check("bp_resp", {28'h0, r}, {28'h0, exp20[i]});
    end
    idle_capture(LAT + 1);

    // Tag wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(2'd2, 32'h100 + 32'(i * 4), $urandom, r, ct, cd);
      check("wrap_resp", {28'h0, r}, 32'((i % 15) + 1));
    end

    // Out of range
    do_reset();
    step(2'd1, 32'h1000, 32'h0, r, ct, cd);
    check("oor_load_resp", {28'h0, r}, 32'd1);
    step(2'd2, 32'h1000, 32'hFFFFFFFF, r, ct, cd);
    check("oor_store_resp", {28'h0, r}, 32'd2);
    idle_capture(LAT + 1);
    check("oor_cpl_count", cap_tag.size(), 32'd1);
    if (cap_data.size() > 0) check("oor_cpl_data", cap_data[0], 32'h0);
    step(2'd1, 32'h0, 32'h0, r, ct, cd);
    step(2'd1, 32'h40, 32'h0, r, ct, cd);
    idle_capture(LAT + 1);

    // Reset mid-flight
    do_reset();
    step(2'd1, 32'h80, 32'h0, r, ct, cd);
    step(2'd1, 32'h84, 32'h0, r, ct, cd);
    do_reset();
    idle_capture(LAT + 2);
    check("mid_rst_no_cpl", cap_tag.size(), 32'd0);
    step(2'd2, 32'h88, 32'h5, r, ct, cd);
    check("mid_rst_first_tag", {28'h0, r}, 32'd1);

    // Load before store
    dut.memory[8] = 32'h11;
    mem_m[8]      = 32'h11;
    do_reset();
    step(2'd1, 32'h20, 32'h0, r, ct, cd);
    step(2'd2, 32'h20, 32'h22, r, ct, cd);
    step(2'd1, 32'h20, 32'h0, r, ct, cd);
    idle_capture(LAT + 1);
    check("lbs_cpl_count", cap_tag.size(), 32'd2);
    if (cap_data.size() > 1) begin
      check("lbs_old_data", cap_data[0], 32'h11);
      check("lbs_new_data", cap_data[1], 32'h22);
    end

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        c = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) a = $urandom;
        else a = (32'($urandom_range(0, 1100)) << 2) | 32'($urandom_range(0, 3));
        step(c, a, $urandom, r, ct, cd);
      end
    end
    idle_capture(LAT + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
